// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FL_CNT_W   = 3;
  localparam int unsigned TMO_CNT_W  = 8;

  typedef enum logic [1:0] {
    PCTL_RUN      = 2'd0,
    PCTL_MEM_WAIT = 2'd1,
    PCTL_FLUSH    = 2'd2
  } pctl_st_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    w_rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    w_rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    load_use_o = ex_is_load_i & (ex_rd_i != '0) & (w_rs1_hit | w_rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates memory wait, jump flush, load-use and
// external stall into per-stage hold_n and flush strobes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_is_load_i,
  input  logic        jmp_flag_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        ext_stall_i,
  output logic        hold_pc_n_o,
  output logic        hold_if_id_n_o,
  output logic        hold_id_ex_n_o,
  output logic        hold_ex_mem_n_o,
  output logic        hold_mem_wb_n_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        mem_tmo_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [FL_CNT_W-1:0]  FL_RELOAD = FL_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(MEM_TIMEOUT);

  pctl_st_e               r_state;
  logic [FL_CNT_W-1:0]    r_fl_cnt;
  logic [TMO_CNT_W-1:0]   r_tmo_cnt;
  logic [31:0]            r_stall_cnt;

  pctl_st_e               w_nxt_state;
  logic [FL_CNT_W-1:0]    w_nxt_fl_cnt;
  logic [TMO_CNT_W-1:0]   w_nxt_tmo_cnt;
  logic                   w_load_use;
  logic                   w_mem_wait;
  logic                   w_hold_front;  // pc, if_id
  logic                   w_hold_back;   // id_ex, ex_mem, mem_wb

  hazard_det u_hazard_det (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_is_load_i (ex_is_load_i),
    .load_use_o   (w_load_use)
  );

  assign w_mem_wait = mem_req_i & ~mem_ack_i;

  // Prioritised decode of strobes and next state from current state and inputs.
  always_comb begin
    w_hold_front  = 1'b1;
    w_hold_back   = 1'b1;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    mem_tmo_o     = 1'b0;
    w_nxt_state   = r_state;
    w_nxt_fl_cnt  = r_fl_cnt;
    w_nxt_tmo_cnt = r_tmo_cnt;
    case (r_state)
      PCTL_RUN: begin
        if (w_mem_wait) begin
          w_hold_front  = 1'b0;
          w_hold_back   = 1'b0;
          w_nxt_state   = PCTL_MEM_WAIT;
          w_nxt_tmo_cnt = TMO_CNT_W'(1);
        end else if (jmp_flag_i) begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_nxt_state  = PCTL_FLUSH;
            w_nxt_fl_cnt = FL_RELOAD;
          end
        end else if (w_load_use) begin
          // Only one bubble is needed: the load moves on to MEM next cycle.
          w_hold_front  = 1'b0;
          flush_id_ex_o = 1'b1;
        end else if (ext_stall_i) begin
          w_hold_front = 1'b0;
          w_hold_back  = 1'b0;
        end
      end
      PCTL_MEM_WAIT: begin
        if (mem_ack_i) begin
          w_nxt_state   = PCTL_RUN;
          w_nxt_tmo_cnt = '0;
        end else if (r_tmo_cnt == TMO_LIMIT) begin
          mem_tmo_o     = 1'b1;
          w_nxt_state   = PCTL_RUN;
          w_nxt_tmo_cnt = '0;
        end else begin
          w_hold_front  = 1'b0;
          w_hold_back   = 1'b0;
          w_nxt_tmo_cnt = r_tmo_cnt + TMO_CNT_W'(1);
        end
      end
      PCTL_FLUSH: begin
        if (w_mem_wait) begin
          w_hold_front  = 1'b0;
          w_hold_back   = 1'b0;
          w_nxt_state   = PCTL_MEM_WAIT;
          w_nxt_tmo_cnt = TMO_CNT_W'(1);
          w_nxt_fl_cnt  = '0;
        end else begin
          flush_if_id_o = 1'b1;
          if (jmp_flag_i) begin
            flush_id_ex_o = 1'b1;
            w_nxt_fl_cnt  = FL_RELOAD;
          end else begin
            w_nxt_fl_cnt = r_fl_cnt - FL_CNT_W'(1);
            if (r_fl_cnt <= FL_CNT_W'(1)) begin
              w_nxt_state  = PCTL_RUN;
              w_nxt_fl_cnt = '0;
            end
          end
        end
      end
      default: begin
        w_nxt_state   = PCTL_RUN;
        w_nxt_fl_cnt  = '0;
        w_nxt_tmo_cnt = '0;
      end
    endcase
  end

  assign hold_pc_n_o     = w_hold_front;
  assign hold_if_id_n_o  = w_hold_front;
  assign hold_id_ex_n_o  = w_hold_back;
  assign hold_ex_mem_n_o = w_hold_back;
  assign hold_mem_wb_n_o = w_hold_back;
  assign stall_cnt_o     = r_stall_cnt;

  // State, counters and saturating PC-stall cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PCTL_RUN;
      r_fl_cnt    <= '0;
      r_tmo_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_fl_cnt  <= w_nxt_fl_cnt;
      r_tmo_cnt <= w_nxt_tmo_cnt;
      if (!w_hold_front) r_stall_cnt <= sat_inc32(r_stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expected
// strobes per cycle, the monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic        id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0, ex_is_load_i = 1'b0;
  logic        jmp_flag_i = 1'b0, mem_req_i = 1'b0, mem_ack_i = 1'b0, ext_stall_i = 1'b0;
  logic        hold_pc_n_o, hold_if_id_n_o, hold_id_ex_n_o, hold_ex_mem_n_o, hold_mem_wb_n_o;
  logic        flush_if_id_o, flush_id_ex_o, mem_tmo_o;
  logic [31:0] stall_cnt_o;

  localparam logic [4:0] H1 = 5'b11111;  // all stages advance
  localparam logic [4:0] HL = 5'b00111;  // pc/if_id held, rest advance
  localparam logic [4:0] H0 = 5'b00000;  // everything frozen

  typedef struct packed {
    logic [4:0]  hold;
    logic        fif;
    logic        fex;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t  q_exp[$];
  string q_nm[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_use_rs1_i    (id_use_rs1_i),
    .id_use_rs2_i    (id_use_rs2_i),
    .ex_rd_i         (ex_rd_i),
    .ex_is_load_i    (ex_is_load_i),
    .jmp_flag_i      (jmp_flag_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .ext_stall_i     (ext_stall_i),
    .hold_pc_n_o     (hold_pc_n_o),
    .hold_if_id_n_o  (hold_if_id_n_o),
    .hold_id_ex_n_o  (hold_id_ex_n_o),
    .hold_ex_mem_n_o (hold_ex_mem_n_o),
    .hold_mem_wb_n_o (hold_mem_wb_n_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o),
    .mem_tmo_o       (mem_tmo_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (q_exp.size() > 0) begin
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      a.hold = {hold_pc_n_o, hold_if_id_n_o, hold_id_ex_n_o, hold_ex_mem_n_o, hold_mem_wb_n_o};
      a.fif  = flush_if_id_o;
      a.fex  = flush_id_ex_o;
      a.tmo  = mem_tmo_o;
      a.cnt  = stall_cnt_o;
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got hold=%b fif=%b fex=%b tmo=%b cnt=%0d, expected hold=%b fif=%b fex=%b tmo=%b cnt=%0d",
                 nm, a.hold, a.fif, a.fex, a.tmo, a.cnt, e.hold, e.fif, e.fex, e.tmo, e.cnt);
      end
    end
  end

  // Advance one cycle, apply inputs, and queue the expected response.
  task automatic cyc(input string nm, input logic rst,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic ld, input logic jmp,
                     input logic req, input logic ack, input logic ext,
                     input logic [4:0] eh, input logic efi, input logic efe, input logic et,
                     input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    id_rs1_i = rs1; id_use_rs1_i = u1;
    id_rs2_i = rs2; id_use_rs2_i = u2;
    ex_rd_i = rd;   ex_is_load_i = ld;
    jmp_flag_i = jmp; mem_req_i = req; mem_ack_i = ack; ext_stall_i = ext;
    e.hold = eh; e.fif = efi; e.fex = efe; e.tmo = et; e.cnt = ec;
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //   name          rst rs1 u1 rs2 u2 rd  ld jmp req ack ext   hold fi fe to cnt
    cyc("reset",       0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 0);
    cyc("idle0",       1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 0);
    // load-use on rs1: one bubble, then advance
    cyc("lu_rs1",      1,  5, 1, 0, 0, 5, 1, 0, 0, 0, 0,  HL, 0, 1, 0, 0);
    cyc("lu_after",    1,  5, 1, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 1);
    cyc("lu_rd0",      1,  0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  H1, 0, 0, 0, 1);
    cyc("lu_nouse",    1,  5, 0, 0, 0, 5, 1, 0, 0, 0, 0,  H1, 0, 0, 0, 1);
    cyc("lu_rs2",      1,  0, 0, 7, 1, 7, 1, 0, 0, 0, 0,  HL, 0, 1, 0, 1);
    cyc("not_load",    1,  5, 1, 0, 0, 5, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 2);
    cyc("ext_stall",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  H0, 0, 0, 0, 2);
    cyc("ext_after",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 3);
    // jump with two-cycle flush
    cyc("jmp_c1",      1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  H1, 1, 1, 0, 3);
    cyc("jmp_c2",      1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 1, 0, 0, 3);
    cyc("jmp_done",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 3);
    // jump beats load-use; a second jump in FLUSH reloads the count
    cyc("jmp_lu",      1,  5, 1, 0, 0, 5, 1, 1, 0, 0, 0,  H1, 1, 1, 0, 3);
    cyc("rejmp",       1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  H1, 1, 1, 0, 3);
    cyc("rejmp_fl",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 1, 0, 0, 3);
    cyc("rejmp_done",  1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 3);
    // memory wait released by ack after three stalled cycles
    cyc("mw_c1",       1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 3);
    cyc("mw_c2",       1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 4);
    cyc("mw_c3",       1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 5);
    cyc("mw_ack",      1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  H1, 0, 0, 0, 6);
    cyc("mw_after",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 6);
    cyc("req_ack_same",1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  H1, 0, 0, 0, 6);
    // memory timeout at MEM_TIMEOUT=4
    cyc("tmo_c1",      1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 6);
    cyc("tmo_c2",      1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 7);
    cyc("tmo_c3",      1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 8);
    cyc("tmo_c4",      1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 9);
    cyc("tmo_release", 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 1, 10);
    cyc("tmo_after",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 10);
    // memory wait during FLUSH discards the remaining flush
    cyc("fl_jmp",      1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  H1, 1, 1, 0, 10);
    cyc("fl_memwait",  1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0, 0, 0, 0, 10);
    cyc("fl_ack",      1,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  H1, 0, 0, 0, 11);
    cyc("fl_after",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 11);
    // all hazards at once, then reset mid-MEM_WAIT
    cyc("all_three",   1,  5, 1, 0, 0, 5, 1, 1, 1, 0, 0,  H0, 0, 0, 0, 11);
    cyc("mw_frozen",   1,  5, 1, 0, 0, 5, 1, 1, 1, 0, 0,  H0, 0, 0, 0, 12);
    cyc("rst_mid_mw",  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 0);
    cyc("rst_release", 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 0);
    cyc("post_rst",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
